// File: rtl/mp_add_pkg.sv
// Shared types and sizing helpers for the multi-precision add sequencer.
// Pure declarations: no latency, no flow control.
package mp_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mp_state_e;

  localparam int MP_BITS    = 64;
  localparam int MP_WORDS   = 4;
  localparam int MP_ADD_LAT = 2;

  // Both widths are clamped to 1 so degenerate configs still elaborate.
  function automatic int idx_w(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

  function automatic int cnt_w(input int lat);
    return (lat > 0) ? $clog2(lat + 1) : 1;
  endfunction

endpackage

// File: rtl/mp_add_slice_mux.sv
// Picks word[idx] out of a packed multi-word operand.
// Combinational, zero latency; no flow control.
module mp_add_slice_mux
  import mp_add_pkg::*;
#(
  parameter int BITS  = MP_BITS,
  parameter int WORDS = MP_WORDS,
  parameter int IW    = idx_w(MP_WORDS)
) (
  input  logic [WORDS*BITS-1:0] vec,
  input  logic [IW-1:0]         idx,
  output logic [BITS-1:0]       slice
);

  always_comb begin
    slice = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (idx == IW'(i)) slice = vec[i*BITS +: BITS];
    end
  end

endmodule

// File: rtl/mp_add_seq.sv
// WORDS*BITS add sequenced word-by-word through an external ADD_LAT-stage adder; MPADD_SOVF_EN adds sovf.
// Latency: out_valid WORDS*(ADD_LAT+1) edges after accept.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
module mp_add_seq
  import mp_add_pkg::*;
#(
  parameter int BITS    = MP_BITS,
  parameter int WORDS   = MP_WORDS,
  parameter int ADD_LAT = MP_ADD_LAT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORDS*BITS-1:0] in_a,
  input  logic [WORDS*BITS-1:0] in_b,
  input  logic                  in_c,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORDS*BITS:0]   out_s,
  output logic [BITS-1:0]       add_a,
  output logic [BITS-1:0]       add_b,
  output logic                  add_c,
  input  logic [BITS:0]         add_s,
`ifdef MPADD_SOVF_EN
  output logic                  sovf,
`endif
  output logic                  busy
);

  localparam int TW = WORDS * BITS;
  localparam int IW = idx_w(WORDS);
  localparam int CW = cnt_w(ADD_LAT);

  mp_state_e         state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d, idx_nxt;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [TW-1:0]     a_q, a_d, b_q, b_d;
  logic [BITS-1:0]   add_a_q, add_a_d, add_b_q, add_b_d;
  logic              add_c_q, add_c_d;
  logic [TW:0]       sum_q, sum_d;
  logic              out_valid_q, out_valid_d;
  logic [BITS-1:0]   slice_a, slice_b;
`ifdef MPADD_SOVF_EN
  logic              sovf_q, sovf_d;
`endif

  assign idx_nxt = idx_q + IW'(1);

  mp_add_slice_mux #(.BITS(BITS), .WORDS(WORDS), .IW(IW)) u_mux_a (
    .vec(a_q), .idx(idx_nxt), .slice(slice_a)
  );
  mp_add_slice_mux #(.BITS(BITS), .WORDS(WORDS), .IW(IW)) u_mux_b (
    .vec(b_q), .idx(idx_nxt), .slice(slice_b)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    add_c_d     = add_c_q;
    sum_d       = sum_q;
    out_valid_d = out_valid_q;
`ifdef MPADD_SOVF_EN
    sovf_d      = sovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          add_a_d = in_a[BITS-1:0];
          add_b_d = in_b[BITS-1:0];
          add_c_d = in_c;
          idx_d   = '0;
          cnt_d   = CW'(ADD_LAT);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          for (int i = 0; i < WORDS; i++) begin
            if (idx_q == IW'(i)) sum_d[i*BITS +: BITS] = add_s[BITS-1:0];
          end
          if (idx_q != IW'(WORDS - 1)) begin
            add_a_d = slice_a;
            add_b_d = slice_b;
            add_c_d = add_s[BITS];
            idx_d   = idx_nxt;
            cnt_d   = CW'(ADD_LAT);
          end else begin
            sum_d[TW]   = add_s[BITS];
            out_valid_d = 1'b1;
            state_d     = DONE;
`ifdef MPADD_SOVF_EN
            // Carry into the MSB is recovered from the sum bit and both operand MSBs.
            sovf_d = add_s[BITS-1] ^ a_q[TW-1] ^ b_q[TW-1] ^ add_s[BITS];
`endif
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      add_c_q     <= 1'b0;
      sum_q       <= '0;
      out_valid_q <= 1'b0;
`ifdef MPADD_SOVF_EN
      sovf_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      add_c_q     <= add_c_d;
      sum_q       <= sum_d;
      out_valid_q <= out_valid_d;
`ifdef MPADD_SOVF_EN
      sovf_q      <= sovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_s     = sum_q;
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign add_c     = add_c_q;
`ifdef MPADD_SOVF_EN
  assign sovf      = sovf_q;
`endif

endmodule
